sram_pattern_master: RTL and testbench

//  Avalon-MM master that drives the 16-bit SRAM controller slave (address/byteenable/read/write/

---
 rtl/sram_pattern_master.sv | 211 +++++++++++++++++++++
 tb/tb_sram_pattern_master.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_pattern_master.sv
// Avalon-MM bring-up master for the 16-bit SRAM controller: writes an address-derived pattern,
// reads it back with up to MAX_PENDING outstanding reads and counts mismatching words.
module sram_pattern_master #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic [DATA_W-1:0]   seed,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W-1:0]   readdata,
    input  logic                readdatavalid,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   first_err_addr
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned PEND_W = 4;
    localparam logic [PEND_W-1:0] MaxPend  = PEND_W'(MAX_PENDING);
    localparam logic [ADDR_W:0]   CntOne   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  ErrOne   = CNT_W'(1);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    // Low data-width slice of the address XOR seed XOR the remaining high address bits.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] s);
        logic [ADDR_W+2*DATA_W-1:0] ext;
        ext = {{(2*DATA_W){1'b0}}, a};
        return ext[DATA_W-1:0] ^ s ^ ext[2*DATA_W-1:DATA_W];
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic [ADDR_W-1:0]   resp_addr_q, resp_addr_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [ADDR_W-1:0]   first_q, first_d;
    logic                rsp_ok;
    logic [ADDR_W-1:0]   next_addr;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        seed_d      = seed_q;
        cnt_d       = cnt_q;
        resp_addr_d = resp_addr_q;
        address_d   = address_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        pass_d      = pass_q;
        err_d       = err_q;
        first_d     = first_q;
        read_d      = 1'b0;
        write_d     = 1'b0;
        done_d      = 1'b0;

        // Responses with nothing outstanding are strays and must not touch the counters.
        rsp_ok    = readdatavalid && (pending_q != '0);
        pending_d = pending_q + PEND_W'(read_q) - PEND_W'(rsp_ok);
        next_addr = base_q + cnt_q[ADDR_W-1:0];

        if (rsp_ok) begin
            resp_addr_d = resp_addr_q + AddrOne;
            if (readdata != pattern(resp_addr_q, seed_q)) begin
                if (err_q != '1) err_d = err_q + ErrOne;
                if (err_q == '0) first_d = resp_addr_q;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d      = base_addr;
                    len_d       = length;
                    seed_d      = seed;
                    resp_addr_d = base_addr;
                    err_d       = '0;
                    first_d     = '0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    if (length == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d   = StWrite;
                        write_d   = 1'b1;
                        address_d = base_addr;
                        wdata_d   = pattern(base_addr, seed);
                        cnt_d     = CntOne;
                    end
                end
            end
            StWrite: begin
                if (cnt_q != len_q) begin
                    write_d   = 1'b1;
                    address_d = next_addr;
                    wdata_d   = pattern(next_addr, seed_q);
                    cnt_d     = cnt_q + CntOne;
                end else begin
                    // First read goes out straight after the last write.
                    state_d   = StRead;
                    read_d    = 1'b1;
                    address_d = base_q;
                    cnt_d     = CntOne;
                end
            end
            StRead: begin
                if (cnt_q == len_q) begin
                    state_d = StDrain;
                end else if (pending_d < MaxPend) begin
                    read_d    = 1'b1;
                    address_d = next_addr;
                    cnt_d     = cnt_q + CntOne;
                end
            end
            StDrain: begin
                if (pending_q == '0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0);
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        be_d = (read_d || write_d) ? '1 : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            base_q      <= '0;
            len_q       <= '0;
            seed_q      <= '0;
            cnt_q       <= '0;
            pending_q   <= '0;
            resp_addr_q <= '0;
            address_q   <= '0;
            be_q        <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            first_q     <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            seed_q      <= seed_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            resp_addr_q <= resp_addr_d;
            address_q   <= address_d;
            be_q        <= be_d;
            read_q      <= read_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            first_q     <= first_d;
        end
    end

    assign address        = address_q;
    assign byteenable     = be_q;
    assign read           = read_q;
    assign write          = write_q;
    assign writedata      = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;

endmodule

// File: tb/tb_sram_pattern_master.sv
// Bench for sram_pattern_master: latency-configurable SRAM model with fault injection, directed
// vector table, reset-abort sequence and randomized runs against an arithmetic reference.
module tb_sram_pattern_master;

    localparam int AW   = 20;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int MAXP = 4;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [DW-1:0] seed;
    logic [AW-1:0] address;
    logic [1:0]    byteenable;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] err_count;
    logic [AW-1:0] first_err_addr;

    sram_pattern_master #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MAX_PENDING(MAXP),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .seed          (seed),
        .address       (address),
        .byteenable    (byteenable),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_addr(first_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic [DW-1:0] s);
        return a[15:0] ^ s ^ {12'h000, a[19:16]};
    endfunction

    // SRAM model state
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            lat = 2;
    bit            f_en = 0;
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_or = '0;
    logic [DW-1:0] f_xor = '0;
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t          rq[$];
    int            cyc = 0;
    int            pend = 0;
    int            viol = 0;
    int            done_cnt = 0;
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    logic [AW-1:0] ra_q[$];

    // Slave + protocol monitor; all sampling on the falling edge, away from DUT updates.
    initial begin
        readdatavalid = 1'b0;
        readdata      = '0;
        forever begin
            rsp_t          r;
            logic [DW-1:0] d;
            @(negedge clk);
            cyc++;
            if (!reset) begin
                pend = 0;
            end else begin
                if (read && write) viol++;
                if (read && pend >= MAXP) viol++;
                if (byteenable !== ((read || write) ? 2'b11 : 2'b00)) viol++;
                if (done) done_cnt++;
                if (write) begin
                    mem[address] = writedata;
                    wa_q.push_back(address);
                    wd_q.push_back(writedata);
                end
                if (read) begin
                    d = mem.exists(address) ? mem[address] : '0;
                    if (f_en && address == f_addr) d = (d | f_or) ^ f_xor;
                    r.due  = cyc + lat;
                    r.data = d;
                    rq.push_back(r);
                    ra_q.push_back(address);
                    pend++;
                end
            end
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                r             = rq.pop_front();
                readdatavalid = 1'b1;
                readdata      = r.data;
                if (pend > 0) pend--;
            end else begin
                readdatavalid = 1'b0;
                readdata      = DW'($urandom);
            end
        end
    end

    // Expected outcome from the pattern rule and the fault description alone.
    task automatic model(input logic [AW-1:0] b, input int len, input logic [DW-1:0] s,
                         input bit fe, input logic [AW-1:0] fa, input logic [DW-1:0] fo,
                         input logic [DW-1:0] fx, output int e, output logic [AW-1:0] f);
        e = 0;
        f = '0;
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] good;
            logic [DW-1:0] got;
            a    = b + AW'(i);
            good = pat(a, s);
            got  = (fe && a == fa) ? ((good | fo) ^ fx) : good;
            if (got != good) begin
                if (e == 0) f = a;
                e++;
            end
        end
    endtask

    task automatic run(input string tag, input logic [AW-1:0] b, input int len,
                       input logic [DW-1:0] s, input int l, input bit fe,
                       input logic [AW-1:0] fa, input logic [DW-1:0] fo, input logic [DW-1:0] fx,
                       input bit poke, output int cycles, output int e_act,
                       output logic [AW-1:0] f_act, output logic p_act);
        int t;
        bit seen;
        int bad;
        lat    = l;
        f_en   = fe;
        f_addr = fa;
        f_or   = fo;
        f_xor  = fx;
        mem.delete();
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        @(negedge clk);
        done_cnt  = 0;
        viol      = 0;
        start     = 1'b1;
        base_addr = b;
        length    = (AW+1)'(len);
        seed      = s;
        t         = 0;
        seen      = 0;
        while (!seen && t < 2000) begin
            @(negedge clk);
            t++;
            if (t == 1) start = 1'b0;
            if (poke && t == 3) begin
                start     = 1'b1;
                base_addr = b ^ 20'h00555;
                length    = 21'd2;
            end
            if (poke && t == 4) start = 1'b0;
            if (done) seen = 1;
        end
        chk({tag, ".done_seen"}, 64'(seen), 64'd1);
        cycles = t;
        e_act  = int'(err_count);
        f_act  = first_err_addr;
        p_act  = pass;
        @(negedge clk);
        chk({tag, ".busy_after"}, 64'(busy), 64'd0);
        chk({tag, ".done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, ".protocol"}, 64'(viol), 64'd0);
        chk({tag, ".n_writes"}, 64'(wa_q.size()), 64'(len));
        chk({tag, ".n_reads"}, 64'(ra_q.size()), 64'(len));
        bad = 0;
        for (int i = 0; i < len && i < wa_q.size(); i++) begin
            logic [AW-1:0] a;
            a = b + AW'(i);
            if (wa_q[i] !== a || wd_q[i] !== pat(a, s)) bad++;
            if (i < ra_q.size() && ra_q[i] !== a) bad++;
        end
        chk({tag, ".addr_data_seq"}, 64'(bad), 64'd0);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int            len;
        logic [DW-1:0] seed;
        int            lat;
        bit            fe;
        logic [AW-1:0] fa;
        logic [DW-1:0] fo;
        logic [DW-1:0] fx;
        bit            poke;
        int            max_cyc;
        int            exp_err;
        logic [AW-1:0] exp_first;
        bit            exp_pass;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int            cycles;
        int            e;
        logic [AW-1:0] f;
        logic          p;
        int            me;
        logic [AW-1:0] mf;
        int            t;

        vecs[0] = '{20'h00000, 8,  16'h0000, 2, 0, 20'h0,     16'h0, 16'h0,    0, 20,   0, 20'h0,     1};
        vecs[1] = '{20'h00100, 16, 16'hA5A5, 2, 1, 20'h00105, 16'h1, 16'h0,    0, 2000, 1, 20'h00105, 0};
        vecs[2] = '{20'h03000, 32, 16'h5A5A, 8, 0, 20'h0,     16'h0, 16'h0,    0, 2000, 0, 20'h0,     1};
        vecs[3] = '{20'hFFFFE, 4,  16'h0F0F, 3, 0, 20'h0,     16'h0, 16'h0,    0, 2000, 0, 20'h0,     1};
        vecs[4] = '{20'h00040, 0,  16'h0000, 2, 0, 20'h0,     16'h0, 16'h0,    0, 1,    0, 20'h0,     1};
        vecs[5] = '{20'h00080, 6,  16'h1111, 1, 0, 20'h0,     16'h0, 16'h0,    1, 2000, 0, 20'h0,     1};
        vecs[6] = '{20'h00010, 5,  16'h0000, 4, 1, 20'h00014, 16'h0, 16'h8000, 0, 2000, 1, 20'h00014, 0};
        vecs[7] = '{20'h00100, 16, 16'hA5A5, 2, 1, 20'h00104, 16'h1, 16'h0,    0, 2000, 0, 20'h0,     1};

        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        seed      = '0;
        repeat (3) @(negedge clk);
        chk("reset.strobes", {read, write, byteenable}, 64'd0);
        chk("reset.status", {busy, done, pass}, 64'd0);
        chk("reset.regs", {address, writedata, err_count, first_err_addr}, 64'd0);
        #1 reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run(tag, vecs[i].base, vecs[i].len, vecs[i].seed, vecs[i].lat, vecs[i].fe,
                vecs[i].fa, vecs[i].fo, vecs[i].fx, vecs[i].poke, cycles, e, f, p);
            chk({tag, ".err_count"}, 64'(e), 64'(vecs[i].exp_err));
            chk({tag, ".first_err"}, 64'(f), 64'(vecs[i].exp_first));
            chk({tag, ".pass"}, 64'(p), 64'(vecs[i].exp_pass));
            chk({tag, ".cycle_bound"}, 64'(cycles <= vecs[i].max_cyc), 64'd1);
        end

        // Reset asserted while reads are outstanding.
        lat      = 8;
        f_en     = 0;
        done_cnt = 0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 20'h02000;
        length    = 21'd16;
        seed      = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        t     = 0;
        while (!read && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("abort.reached_read", 64'(read), 64'd1);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort.strobes", {read, write, byteenable}, 64'd0);
        chk("abort.address", 64'(address), 64'd0);
        chk("abort.writedata", 64'(writedata), 64'd0);
        chk("abort.status", {busy, done, pass}, 64'd0);
        chk("abort.err_regs", {err_count, first_err_addr}, 64'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        repeat (16) @(negedge clk);
        chk("abort.stray_err", 64'(err_count), 64'd0);
        chk("abort.no_done", 64'(done_cnt), 64'd0);
        chk("abort.idle", 64'(busy), 64'd0);
        run("after_abort", 20'h02000, 16, 16'h1234, 3, 0, 20'h0, 16'h0, 16'h0, 0,
            cycles, e, f, p);
        chk("after_abort.pass", 64'(p), 64'd1);
        chk("after_abort.err_count", 64'(e), 64'd0);

        for (int k = 0; k < 10; k++) begin
            logic [AW-1:0] b;
            int            len;
            logic [DW-1:0] s;
            int            l;
            bit            fe;
            logic [AW-1:0] fa;
            logic [DW-1:0] fx;
            string         tag;
            tag = $sformatf("rnd%0d", k);
            b   = ($urandom_range(0, 2) == 0) ? 20'hFFFFF - AW'($urandom_range(0, 20))
                                               : AW'($urandom);
            len = $urandom_range(0, 40);
            s   = DW'($urandom);
            l   = $urandom_range(1, 10);
            fe  = 1'($urandom_range(0, 1));
            fa  = b + AW'($urandom_range(0, len + 3));
            fx  = ($urandom_range(0, 3) == 0) ? 16'h0000 : DW'(1 << $urandom_range(0, 15));
            model(b, len, s, fe, fa, 16'h0000, fx, me, mf);
            run(tag, b, len, s, l, fe, fa, 16'h0000, fx, 0, cycles, e, f, p);
            chk({tag, ".err_count"}, 64'(e), 64'(me));
            chk({tag, ".first_err"}, 64'(f), 64'(mf));
            chk({tag, ".pass"}, 64'(p), 64'(me == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
